// File: rtl/handshake_const_check.sv
// Constant-token checker: compares each input token with CONST_VALUE and emits one control
// token carrying the match bit, through a 2-entry skid buffer, with saturating debug counters.
module handshake_const_check #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 14,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_valid,
  output logic                  ctrl_match,
  input  logic                  ctrl_ready,
  output logic [CNT_WIDTH-1:0]  tok_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  localparam logic [DATA_WIDTH-1:0] ConstExt = DATA_WIDTH'(CONST_VALUE);
  localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;

  state_e               state_q, state_d;
  logic                 head_q, head_d;
  logic                 skid_q, skid_d;
  logic [CNT_WIDTH-1:0] tok_q, tok_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 sticky_q, sticky_d;

  logic in_fire, out_fire, match;

  // Handshake outputs come straight from state flops: no ready-to-ready path.
  assign ins_ready  = (state_q != StFull);
  assign ctrl_valid = (state_q != StEmpty);
  assign ctrl_match = (state_q != StEmpty) & head_q;

  assign in_fire  = ins_valid & ins_ready;
  assign out_fire = ctrl_valid & ctrl_ready;
  assign match    = (ins == ConstExt);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          head_d  = match;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          head_d = match;
        end else if (in_fire) begin
          state_d = StFull;
          skid_d  = match;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d = StOne;
          head_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    tok_d    = tok_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    if (out_fire) begin
      if (tok_q != CntMax) tok_d = tok_q + 1'b1;
      if (!head_q) begin
        if (err_q != CntMax) err_d = err_q + 1'b1;
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StEmpty;
      head_q   <= 1'b0;
      skid_q   <= 1'b0;
      tok_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
      tok_q    <= tok_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign tok_count  = tok_q;
  assign err_count  = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_handshake_const_check.sv
// Scoreboard bench: match bits are queued at input fire and compared at output fire; a 4-bit
// counter instance shares the stimulus for the saturation case.
module tb_handshake_const_check;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ctrl_ready = 1'b0;

  logic        ins_ready, ctrl_valid, ctrl_match, err_sticky;
  logic [15:0] tok_count, err_count;
  logic        ins_ready_s, ctrl_valid_s, ctrl_match_s, err_sticky_s;
  logic [3:0]  tok_count_s, err_count_s;

  handshake_const_check #(.DATA_WIDTH(32), .CONST_VALUE(14), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ctrl_valid(ctrl_valid), .ctrl_match(ctrl_match), .ctrl_ready(ctrl_ready),
    .tok_count(tok_count), .err_count(err_count), .err_sticky(err_sticky)
  );

  handshake_const_check #(.DATA_WIDTH(32), .CONST_VALUE(14), .CNT_WIDTH(4)) u_dut_small (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready_s),
    .ctrl_valid(ctrl_valid_s), .ctrl_match(ctrl_match_s), .ctrl_ready(ctrl_ready),
    .tok_count(tok_count_s), .err_count(err_count_s), .err_sticky(err_sticky_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit q[$];
  int exp_tok, exp_err, exp_tok_s, exp_err_s, in_fires;
  bit exp_sticky;

  // Sample mid-cycle: state reflects all earlier fires, then account for the fires at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      bit out_f, in_f, m;
      check("ctrl_valid", ctrl_valid, q.size() != 0);
      check("ins_ready", ins_ready, q.size() != 2);
      check("ctrl_match", ctrl_match, (q.size() != 0) ? q[0] : 1'b0);
      check("tok_count", tok_count, exp_tok);
      check("err_count", err_count, exp_err);
      check("err_sticky", err_sticky, exp_sticky);
      check("tok_count_s", tok_count_s, exp_tok_s);
      check("err_count_s", err_count_s, exp_err_s);
      out_f = (q.size() != 0) && ctrl_ready;
      in_f  = ins_valid && (q.size() != 2);
      if (out_f) begin
        m = q.pop_front();
        if (exp_tok < 65535) exp_tok++;
        if (exp_tok_s < 15) exp_tok_s++;
        if (!m) begin
          if (exp_err < 65535) exp_err++;
          if (exp_err_s < 15) exp_err_s++;
          exp_sticky = 1'b1;
        end
      end
      if (in_f) begin
        q.push_back(ins == 32'd14);
        in_fires++;
      end
    end
  end

  task automatic do_reset();
    ins_valid = 1'b0;
    rst = 1'b0;
    q.delete();
    exp_tok = 0; exp_err = 0; exp_tok_s = 0; exp_err_s = 0; in_fires = 0; exp_sticky = 1'b0;
    #1;
    check("rst ctrl_valid", ctrl_valid, 1'b0);
    check("rst ins_ready", ins_ready, 1'b1);
    check("rst ctrl_match", ctrl_match, 1'b0);
    check("rst tok_count", tok_count, 0);
    check("rst err_count", err_count, 0);
    check("rst err_sticky", err_sticky, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Hold a token on the input until it is accepted (bounded).
  task automatic send(input logic [31:0] v);
    bit ok;
    int budget;
    ins = v;
    ins_valid = 1'b1;
    budget = 50;
    do begin
      ok = ins_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!ok && budget > 0);
    if (!ok) check("send timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget;
    ins_valid = 1'b0;
    ctrl_ready = 1'b1;
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain done", q.size(), 0);
  endtask

  initial begin
    #3;
    do_reset();

    // Reset with two tokens buffered discards them
    ctrl_ready = 1'b0;
    send(32'd14);
    send(32'd15);
    ins_valid = 1'b0;
    check("buffered full", ins_ready, 1'b0);
    do_reset();
    ctrl_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no delivery after reset", tok_count, 0);

    // Streaming matches
    for (int i = 0; i < 5; i++) send(32'd14);
    drain();
    check("stream tok", tok_count, 5);
    check("stream err", err_count, 0);
    check("stream sticky", err_sticky, 1'b0);

    // Mismatch and sticky flag
    do_reset();
    ctrl_ready = 1'b1;
    send(32'd14); send(32'd15); send(32'd14);
    for (int i = 0; i < 10; i++) send(32'd14);
    drain();
    check("mm err", err_count, 1);
    check("mm sticky", err_sticky, 1'b1);
    check("mm tok", tok_count, 13);

    // Backpressure: fill, ignore a third offer, then release for two cycles
    do_reset();
    ctrl_ready = 1'b0;
    ins = 32'd14; ins_valid = 1'b1;
    @(posedge clk); #1;
    ins = 32'd0;
    @(posedge clk); #1;
    check("bp ins_ready low", ins_ready, 1'b0);
    @(posedge clk); #1;
    check("bp held match", ctrl_match, 1'b1);
    ins_valid = 1'b0;
    ctrl_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctrl_ready = 1'b0;
    check("bp ins_ready back", ins_ready, 1'b1);
    check("bp tok", tok_count, 2);
    check("bp err", err_count, 1);
    @(posedge clk); #1;

    // Alternating ready with continuous input
    do_reset();
    for (int i = 0; i < 24; i++) begin
      ctrl_ready = i[0];
      ins = ($urandom_range(0, 1) != 0) ? 32'd14 : $urandom;
      ins_valid = 1'b1;
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
    ctrl_ready = 1'b0;
    @(posedge clk); #1;
    check("alt conservation", tok_count, in_fires - q.size());
    drain();
    check("alt all delivered", tok_count, in_fires);

    // Saturation of the 4-bit counters
    do_reset();
    ctrl_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(32'd3 + i);
    drain();
    check("sat tok_s", tok_count_s, 15);
    check("sat err_s", err_count_s, 15);
    check("sat tok", tok_count, 20);
    repeat (3) @(posedge clk);
    #1;
    check("sat hold", tok_count_s, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
